gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable response checker for the two-input gate unit: the receiving end of the gate stimulus sequence. It samples the unit's inputs and its `and_out`/`or_out`/`xor_out` responses on a valid strobe, computes the expected results, and counts vectors and mismatches. It records the first failing vector and reports a pass/fail verdict after a programmed number of vectors. It sits beside the gate unit in on-chip self-test and is reused for bring-up of later FMAC datapath stages.

## Interface

Parameters:
- `NUM_VEC`, default 4. Number of valid vectors per run, 1 to 2^CNT_W−1.
- `CNT_W`, default 8. Width of all counters and indices.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a run; sampled in IDLE and DONE.
- `in_valid`  in  1  the vector on `a`, `b` and the three responses is valid this cycle.
- `a`  in  1  gate input a, as applied to the unit.
- `b`  in  1  gate input b, as applied to the unit.
- `and_out`  in  1  unit response.
- `or_out`  in  1  unit response.
- `xor_out`  in  1  unit response.
- `busy`  out  1  high in CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_cnt`==0.
- `err_pulse`  out  1  one-cycle strobe per mismatching vector.
- `vec_cnt`  out  CNT_W  valid vectors checked in the current run.
- `err_cnt`  out  CNT_W  mismatching vectors, saturating.
- `first_err_idx`  out  CNT_W  value of `vec_cnt` before the first failing vector (0-based index).
- `first_err_mask`  out  3  {and, or, xor} mismatch bits of the first failing vector.

## Operation

- FSM states: IDLE, CHECK, DONE.
- IDLE: `start`=1 → CHECK. Before entering CHECK, clear `vec_cnt`, `err_cnt`, `first_err_idx`, `first_err_mask` and the internal first-error flag.
- CHECK, on each cycle with `in_valid`=1:
  - expected values: `a&b`, `a|b`, `a^b`.
  - `mask` = {and_out^(a&b), or_out^(a|b), xor_out^(a^b)}.
  - `vec_cnt` increments.
  - If `mask` != 0:
    - `err_cnt` increments, saturating at 2^CNT_W−1.
    - `err_pulse`=1 on the next cycle.
    - If no error has been recorded yet in this run, capture `first_err_idx` ← old `vec_cnt` and `first_err_mask` ← `mask`.
  - The vector that makes `vec_cnt` reach NUM_VEC → DONE.
- CHECK with `in_valid`=0: hold all state. `start` is ignored in CHECK.
- DONE: hold all results. `pass` = (`err_cnt`==0). `in_valid` is ignored. `start`=1 → clear as from IDLE and go to CHECK.
- `in_valid` in IDLE is ignored; no counter moves.
- An X or Z value on a response bit compares as a mismatch. The bench treats `===` semantics as authoritative.

## Timing

- Reset (`rst_n`=0 at a rising edge), from any state, on the same edge:
  - state → IDLE.
  - `busy`, `done`, `pass`, `err_pulse` = 0.
  - `vec_cnt`, `err_cnt`, `first_err_idx`, `first_err_mask` = 0.
  - Reset wins over simultaneous `start` or `in_valid`.
- `start` sampled at edge N: `busy`=1 and counters cleared from edge N. The first vector can be sampled at edge N+1.
- Latency from a sampled vector to updated `vec_cnt`, `err_cnt`, `err_pulse` and capture registers: 1 cycle.
- Last vector sampled at edge M: `busy`=0, `done`=1 and `pass` valid from edge M. If that vector mismatches, `err_pulse`=1 for the cycle after M, coincident with `done`.
- `in_valid` may be asserted back-to-back every cycle; throughput is 1 vector per cycle.
- `start` and `in_valid` together in DONE: the restart is taken and the vector is ignored.
- `err_cnt` saturates: once at the maximum, further mismatches still pulse `err_pulse`, but the count does not wrap.
- All outputs are registered; none is combinational from the inputs.

## Test plan

1. Correct unit, NUM_VEC=4. Pulse `start`, then apply (a,b)=00,01,10,11 with correct responses on 4 consecutive cycles. Required: `done`=1 and `pass`=1 the cycle after the 4th vector, `err_cnt`=0, `vec_cnt`=4, `err_pulse` never high.
2. Fault injection. On vector index 2 (a=1,b=0), force `or_out`=0. Required: one `err_pulse`, `err_cnt`=1, `first_err_idx`=2, `first_err_mask`=3'b010, `pass`=0.
3. Gapped valids and first-error capture. Deassert `in_valid` between vectors. Inject `xor_out` errors on vectors 1 and 3. Required: `vec_cnt` advances only on valid cycles, `err_cnt`=2, `first_err_idx`=1, `first_err_mask`=3'b001.
4. Reset mid-run. Drop `rst_n` after 2 vectors. Required: all outputs 0 and state IDLE on the next edge. A subsequent `start` plus 4 good vectors gives `pass`=1.
5. Restart from DONE. After a failing run, pulse `start` together with `in_valid`. Required: counters cleared, that vector ignored, and a new run of 4 good vectors gives `pass`=1. `in_valid` asserted in IDLE leaves `vec_cnt`=0.
6. Saturation. CNT_W=2, NUM_VEC=3, all responses inverted. Required: `err_cnt`=3 (maximum, no wrap), `err_pulse` on each of the 3 vectors, `done`=1 after the 3rd vector.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response checker for the two-input gate unit: compares and/or/xor responses
// against a&b, a|b, a^b on each valid strobe and reports counts, first error and verdict.
module gate_response_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             and_out,
  input  logic             or_out,
  input  logic             xor_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_mask
);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  state_t           r_state;
  logic             r_busy, r_done, r_pass, r_err_pulse, r_first_seen;
  logic [CNT_W-1:0] r_vec_cnt, r_err_cnt, r_first_idx;
  logic [2:0]       r_first_mask;

  logic [2:0]       w_mask;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_vec_nxt, w_err_nxt;

  // Case-equality so an X/Z response bit counts as a mismatch in simulation.
  assign w_mask[2]  = !(and_out === (a & b));
  assign w_mask[1]  = !(or_out  === (a | b));
  assign w_mask[0]  = !(xor_out === (a ^ b));
  assign w_mismatch = |w_mask;
  assign w_vec_nxt  = r_vec_cnt + LP_ONE;
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + LP_ONE : r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_first_seen <= 1'b0;
      r_vec_cnt    <= '0;
      r_err_cnt    <= '0;
      r_first_idx  <= '0;
      r_first_mask <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A restart wins over a coincident valid vector.
          if (start) begin
            r_state      <= ST_CHECK;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_first_seen <= 1'b0;
            r_vec_cnt    <= '0;
            r_err_cnt    <= '0;
            r_first_idx  <= '0;
            r_first_mask <= '0;
          end
        end
        ST_CHECK: begin
          if (in_valid) begin
            r_vec_cnt <= w_vec_nxt;
            r_err_cnt <= w_err_nxt;
            if (w_mismatch) begin
              r_err_pulse <= 1'b1;
              if (!r_first_seen) begin
                r_first_seen <= 1'b1;
                r_first_idx  <= r_vec_cnt;
                r_first_mask <= w_mask;
              end
            end
            if (w_vec_nxt == LP_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == '0);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_pulse      = r_err_pulse;
  assign vec_cnt        = r_vec_cnt;
  assign err_cnt        = r_err_cnt;
  assign first_err_idx  = r_first_idx;
  assign first_err_mask = r_first_mask;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: expected run results are queued at
// stimulus time and compared by monitors when each DUT run reports done.
module tb_gate_response_checker;

  typedef struct {
    int vc; int ec; int idx; int mask; int pass; int pulses;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, start2, in_valid2;
  logic a, b, and_out, or_out, xor_out;
  logic busy, done, pass, err_pulse;
  logic [7:0] vec_cnt, err_cnt, first_err_idx;
  logic [2:0] first_err_mask;
  logic busy2, done2, pass2, err_pulse2;
  logic [1:0] vec_cnt2, err_cnt2, first_err_idx2;
  logic [2:0] first_err_mask2;

  int   errors = 0;
  int   checks = 0;
  logic sel = 1'b0;
  rec_t q1[$];
  rec_t q2[$];

  always #5 clk = ~clk;

  gate_response_checker #(.NUM_VEC(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .and_out(and_out), .or_out(or_out), .xor_out(xor_out),
    .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_mask(first_err_mask));

  gate_response_checker #(.NUM_VEC(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
    .a(a), .b(b), .and_out(and_out), .or_out(or_out), .xor_out(xor_out),
    .busy(busy2), .done(done2), .pass(pass2), .err_pulse(err_pulse2),
    .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .first_err_idx(first_err_idx2),
    .first_err_mask(first_err_mask2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input int vc, ec, idx, mask, ps, pulses);
    rec_t r;
    r.vc = vc; r.ec = ec; r.idx = idx; r.mask = mask; r.pass = ps; r.pulses = pulses;
    return r;
  endfunction

  // Monitor for the main instance
  int   pulses1 = 0;
  logic done_q1 = 1'b0;
  always @(negedge clk) begin
    rec_t e;
    if (!rst_n) begin
      pulses1 = 0; done_q1 = 1'b0;
    end else begin
      if (err_pulse) pulses1++;
      if (done && !done_q1) begin
        if (q1.size() == 0) chk("dut_unexpected_done", 1, 0);
        else begin
          e = q1.pop_front();
          chk("dut_vec_cnt", vec_cnt, e.vc);
          chk("dut_err_cnt", err_cnt, e.ec);
          chk("dut_first_idx", first_err_idx, e.idx);
          chk("dut_first_mask", first_err_mask, e.mask);
          chk("dut_pass", pass, e.pass);
          chk("dut_busy_at_done", busy, 0);
          chk("dut_err_pulses", pulses1, e.pulses);
        end
        pulses1 = 0;
      end
      done_q1 = done;
    end
  end

  // Monitor for the saturation instance
  int   pulses2 = 0;
  logic done_q2 = 1'b0;
  always @(negedge clk) begin
    rec_t e;
    if (!rst_n) begin
      pulses2 = 0; done_q2 = 1'b0;
    end else begin
      if (err_pulse2) pulses2++;
      if (done2 && !done_q2) begin
        if (q2.size() == 0) chk("sat_unexpected_done", 1, 0);
        else begin
          e = q2.pop_front();
          chk("sat_vec_cnt", vec_cnt2, e.vc);
          chk("sat_err_cnt", err_cnt2, e.ec);
          chk("sat_first_idx", first_err_idx2, e.idx);
          chk("sat_first_mask", first_err_mask2, e.mask);
          chk("sat_pass", pass2, e.pass);
          chk("sat_err_pulses", pulses2, e.pulses);
        end
        pulses2 = 0;
      end
      done_q2 = done2;
    end
  end

  task automatic vec(input logic va, input logic vb, input logic [2:0] flip);
    a = va; b = vb;
    and_out = (va & vb) ^ flip[2];
    or_out  = (va | vb) ^ flip[1];
    xor_out = (va ^ vb) ^ flip[0];
    if (sel) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go();
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic good_run();
    go();
    vec(0, 0, 3'b000); vec(0, 1, 3'b000); vec(1, 0, 3'b000); vec(1, 1, 3'b000);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(sel ? done2 : done) && n < 20) begin @(posedge clk); #1; n++; end
    chk(nm, sel ? done2 : done, 1);
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
    a = 1'b0; b = 1'b0; and_out = 1'b0; or_out = 1'b0; xor_out = 1'b0;
    idle(2);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_vec_cnt", vec_cnt, 0); chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: correct unit, back-to-back vectors
    q1.push_back(mk(4, 0, 0, 0, 1, 0));
    go();
    chk("t1_busy_after_start", busy, 1);
    vec(0, 0, 3'b000); vec(0, 1, 3'b000); vec(1, 0, 3'b000);
    chk("t1_not_done_early", done, 0);
    vec(1, 1, 3'b000);
    chk("t1_done_after_last", done, 1);
    chk("t1_pass_after_last", pass, 1);
    wait_done("t1_done_timeout");

    // 2: or_out forced low on vector 2
    q1.push_back(mk(4, 1, 2, 3'b010, 0, 1));
    go();
    vec(0, 0, 3'b000); vec(0, 1, 3'b000); vec(1, 0, 3'b010);
    chk("t2_err_pulse_high", err_pulse, 1);
    vec(1, 1, 3'b000);
    chk("t2_err_pulse_low", err_pulse, 0);
    wait_done("t2_done_timeout");

    // 3: gapped valids, xor errors on vectors 1 and 3
    q1.push_back(mk(4, 2, 1, 3'b001, 0, 2));
    go();
    vec(0, 0, 3'b000); idle(1);
    chk("t3_vec_cnt_gap", vec_cnt, 1);
    vec(0, 1, 3'b001); idle(2);
    chk("t3_vec_cnt_gap2", vec_cnt, 2);
    vec(1, 0, 3'b000); idle(1);
    vec(1, 1, 3'b001);
    wait_done("t3_done_timeout");

    // 4: reset mid-run beats coincident start/valid
    go();
    vec(0, 0, 3'b100); vec(0, 1, 3'b000);
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    chk("t4_busy", busy, 0); chk("t4_done", done, 0); chk("t4_pass", pass, 0);
    chk("t4_err_pulse", err_pulse, 0); chk("t4_vec_cnt", vec_cnt, 0);
    chk("t4_err_cnt", err_cnt, 0); chk("t4_first_idx", first_err_idx, 0);
    chk("t4_first_mask", first_err_mask, 0);
    q1.push_back(mk(4, 0, 0, 0, 1, 0));
    good_run();
    wait_done("t4_done_timeout");

    // 5: failing run, then restart from DONE with a coincident valid
    q1.push_back(mk(4, 4, 0, 3'b100, 0, 4));
    go();
    vec(0, 0, 3'b100); vec(0, 1, 3'b100); vec(1, 0, 3'b100); vec(1, 1, 3'b100);
    wait_done("t5a_done_timeout");
    a = 1'b1; b = 1'b1; and_out = 1'b0; or_out = 1'b1; xor_out = 1'b0;
    start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("t5_restart_busy", busy, 1); chk("t5_restart_vec_cnt", vec_cnt, 0);
    chk("t5_restart_err_cnt", err_cnt, 0); chk("t5_restart_mask", first_err_mask, 0);
    idle(1);
    chk("t5_no_pulse_ignored_vec", err_pulse, 0);
    q1.push_back(mk(4, 0, 0, 0, 1, 0));
    vec(0, 0, 3'b000); vec(0, 1, 3'b000); vec(1, 0, 3'b000); vec(1, 1, 3'b000);
    wait_done("t5b_done_timeout");
    vec(0, 0, 3'b111);
    chk("t5_done_ignores_valid", vec_cnt, 4);
    chk("t5_done_holds_pass", pass, 1);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    vec(1, 1, 3'b111);
    chk("t5_idle_ignores_valid", vec_cnt, 0);
    chk("t5_idle_no_err", err_cnt, 0);

    // 6: saturation on CNT_W=2, NUM_VEC=3 instance, all responses inverted
    sel = 1'b1;
    q2.push_back(mk(3, 3, 0, 3'b111, 0, 3));
    go();
    vec(0, 0, 3'b111); vec(0, 1, 3'b111);
    chk("t6_err_cnt_mid", err_cnt2, 2);
    vec(1, 1, 3'b111);
    chk("t6_done2", done2, 1);
    wait_done("t6_done_timeout");
    sel = 1'b0;

    idle(2);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
